boa_div_iter: RTL and testbench

BOA_DIV_ITER -- requirements
Module: boa_div_iter

---
 rtl/boa_div_iter_pkg.sv | 8 +
 rtl/boa_div_iter_if.sv | 29 ++
 rtl/boa_div_step.sv | 24 ++
 rtl/boa_div_iter.sv | 127 ++++++++++++
 tb/tb_boa_div_iter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/boa_div_iter_pkg.sv
// Shared constants for the iterative divider.
// No ports. Provides the default operand width. RISC-V M semantics are
// defined at 32 bits, and other widths scale the same way.
package boa_div_iter_pkg;

  localparam int unsigned BoaDivWidth = 32;

endpackage

// File: rtl/boa_div_iter_if.sv
// Request/response bundle for boa_div_iter.
//   d_valid, u, lhs, rhs, cancel : requester -> divider
//   ready, q_valid, div_res, mod_res : divider -> requester
// The master modport is the requester and the slave modport is the divider.
interface boa_div_iter_if
  import boa_div_iter_pkg::*;
#(
  parameter int unsigned width = BoaDivWidth
);
  logic             d_valid;
  logic             u;
  logic [width-1:0] lhs;
  logic [width-1:0] rhs;
  logic             cancel;
  logic             ready;
  logic             q_valid;
  logic [width-1:0] div_res;
  logic [width-1:0] mod_res;

  modport master (
    output d_valid, u, lhs, rhs, cancel,
    input  ready, q_valid, div_res, mod_res
  );

  modport slave (
    input  d_valid, u, lhs, rhs, cancel,
    output ready, q_valid, div_res, mod_res
  );
endinterface

// File: rtl/boa_div_step.sv
// One restoring radix-2 division step. This module is purely combinational.
//   rem_in  : partial remainder, always < divisor (except for the divide-by-zero case)
//   divisor : unsigned divisor magnitude
//   bit_in  : next dividend bit, taken MSB first
//   rem_out : next partial remainder
//   q_bit   : quotient bit for this step
module boa_div_step #(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0] rem_in,
  input  logic [width-1:0] divisor,
  input  logic             bit_in,
  output logic [width-1:0] rem_out,
  output logic             q_bit
);
  logic [width:0] shifted;
  logic [width:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, divisor};
  // No borrow means shifted >= divisor. Because rem_in < divisor, diff then fits in width bits.
  assign q_bit   = ~diff[width];
  assign rem_out = q_bit ? diff[width-1:0] : shifted[width-1:0];
endmodule

// File: rtl/boa_div_iter.sv
// Fixed-latency iterative signed/unsigned divider with RISC-V M semantics.
//   clk, rst : rising-edge clock and synchronous active-high reset
//   bus      : slave side of boa_div_iter_if (request, cancel, ready, results)
// Flow: IDLE accepts a request, CALC runs width restoring steps, and FIX applies
// the signs and loads the results. q_valid pulses in the cycle after FIX,
// which is width+1 edges after accept.
module boa_div_iter
  import boa_div_iter_pkg::*;
#(
  parameter int unsigned width = BoaDivWidth
) (
  input logic           clk,
  input logic           rst,
  boa_div_iter_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q;
  logic             u_q;
  logic             sign_lhs_q;
  logic             sign_rhs_q;
  logic             rhs_zero_q;
  logic [width-1:0] lhs_orig_q;
  logic [width-1:0] dividend_q;
  logic [width-1:0] divisor_q;
  logic [width-1:0] rem_q;
  logic [width-1:0] quo_q;
  logic [width-1:0] cnt_q;
  logic             q_valid_q;
  logic [width-1:0] div_res_q;
  logic [width-1:0] mod_res_q;

  logic             sign_lhs_in;
  logic             sign_rhs_in;
  logic [width-1:0] step_rem;
  logic             step_q;
  logic [width-1:0] quo_fix;
  logic [width-1:0] rem_fix;

  assign sign_lhs_in = ~bus.u & bus.lhs[width-1];
  assign sign_rhs_in = ~bus.u & bus.rhs[width-1];

  // The signs are already masked by u at accept. Gating again on u_q keeps the intent explicit.
  assign quo_fix = (~u_q & (sign_lhs_q ^ sign_rhs_q)) ? -quo_q : quo_q;
  assign rem_fix = (~u_q & sign_lhs_q) ? -rem_q : rem_q;

  boa_div_step #(
    .width (width)
  ) u_step (
    .rem_in  (rem_q),
    .divisor (divisor_q),
    .bit_in  (dividend_q[width-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      u_q        <= 1'b0;
      sign_lhs_q <= 1'b0;
      sign_rhs_q <= 1'b0;
      rhs_zero_q <= 1'b0;
      lhs_orig_q <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      q_valid_q  <= 1'b0;
      div_res_q  <= '0;
      mod_res_q  <= '0;
    end else begin
      q_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // If cancel arrives together with d_valid, the request is dropped.
          if (bus.d_valid && !bus.cancel) begin
            state_q    <= StCalc;
            u_q        <= bus.u;
            sign_lhs_q <= sign_lhs_in;
            sign_rhs_q <= sign_rhs_in;
            rhs_zero_q <= (bus.rhs == '0);
            lhs_orig_q <= bus.lhs;
            dividend_q <= sign_lhs_in ? -bus.lhs : bus.lhs;
            divisor_q  <= sign_rhs_in ? -bus.rhs : bus.rhs;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
          end
        end
        StCalc: begin
          if (bus.cancel) begin
            state_q <= StIdle;
          end else begin
            rem_q      <= step_rem;
            quo_q      <= {quo_q[width-2:0], step_q};
            dividend_q <= {dividend_q[width-2:0], 1'b0};
            cnt_q      <= cnt_q + 1'b1;
            if (cnt_q == width'(width - 1)) begin
              state_q <= StFix;
            end
          end
        end
        StFix: begin
          state_q <= StIdle;
          if (!bus.cancel) begin
            q_valid_q <= 1'b1;
            if (rhs_zero_q) begin
              div_res_q <= '1;
              mod_res_q <= lhs_orig_q;
            end else begin
              div_res_q <= quo_fix;
              mod_res_q <= rem_fix;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready   = (state_q == StIdle);
  assign bus.q_valid = q_valid_q;
  assign bus.div_res = div_res_q;
  assign bus.mod_res = mod_res_q;
endmodule

// File: tb/tb_boa_div_iter.sv
// Directed self-checking bench for boa_div_iter. Inputs change on the falling
// edge, and outputs are sampled on the falling edge.
module tb_boa_div_iter;
  localparam int unsigned W = 32;
  localparam int Lat = 33;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  boa_div_iter_if #(.width(W)) bus ();

  boa_div_iter #(.width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Independent RISC-V M reference.
  task automatic ref_div(input logic u, input logic [31:0] l, input logic [31:0] r,
                         output logic [31:0] q, output logic [31:0] m);
    logic signed [31:0] sl;
    logic signed [31:0] sr;
    sl = l;
    sr = r;
    if (r == 32'd0) begin
      q = 32'hFFFF_FFFF;
      m = l;
    end else if (u) begin
      q = l / r;
      m = l % r;
    end else if (l == 32'h8000_0000 && r == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      m = 32'd0;
    end else begin
      q = sl / sr;
      m = sl % sr;
    end
  endtask

  // Call at a falling edge. The request is presented for exactly one rising edge.
  task automatic issue(input logic u, input logic [31:0] l, input logic [31:0] r);
    bus.d_valid = 1'b1;
    bus.u       = u;
    bus.lhs     = l;
    bus.rhs     = r;
    @(negedge clk);
    bus.d_valid = 1'b0;
  endtask

  // Counts falling edges until q_valid is seen. The count is bounded.
  task automatic wait_qv(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.q_valid && n < 100);
  endtask

  // Watches for an unwanted q_valid over a fixed window.
  task automatic watch_no_qv(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.q_valid) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic u, input logic [31:0] l,
                        input logic [31:0] r, input logic [31:0] eq, input logic [31:0] em);
    int n;
    issue(u, l, r);
    wait_qv(n);
    check({tag, "_lat"}, 32'(n), 32'(Lat));
    check({tag, "_div"}, bus.div_res, eq);
    check({tag, "_mod"}, bus.mod_res, em);
  endtask

  initial begin
    int n;
    int m;
    logic [31:0] q_exp;
    logic [31:0] m_exp;
    logic [31:0] q_prev;
    logic [31:0] m_prev;
    logic        ru;
    logic [31:0] rl;
    logic [31:0] rr;

    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.d_valid = 1'b0;
    bus.u       = 1'b0;
    bus.lhs     = '0;
    bus.rhs     = '0;
    bus.cancel  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_qv", 32'(bus.q_valid), 32'd0);
    check("rst_div", bus.div_res, 32'd0);
    check("rst_mod", bus.mod_res, 32'd0);

    run_op("udiv", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("sdiv", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("sdiv_neg_rhs", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_op("udiv_big", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
    run_op("sdiv0", 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    run_op("udiv0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    run_op("ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

    // A d_valid pulse while the divider is busy must be dropped without being queued.
    @(negedge clk);
    issue(1'b1, 32'd100, 32'd7);
    check("busy_ready", 32'(bus.ready), 32'd0);
    m = 0;
    repeat (4) begin
      @(negedge clk);
      m++;
    end
    bus.d_valid = 1'b1;
    bus.lhs     = 32'd5;
    bus.rhs     = 32'd1;
    @(negedge clk);
    m++;
    bus.d_valid = 1'b0;
    wait_qv(n);
    check("busy_lat", 32'(m + n), 32'(Lat));
    check("busy_div", bus.div_res, 32'd14);
    check("busy_mod", bus.mod_res, 32'd2);
    watch_no_qv("busy_noqueue", 40);

    // A cancel in cycle 10 must return the divider to IDLE and leave the results untouched.
    q_prev = bus.div_res;
    m_prev = bus.mod_res;
    issue(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_ready", 32'(bus.ready), 32'd1);
    check("cancel_div", bus.div_res, q_prev);
    check("cancel_mod", bus.mod_res, m_prev);
    watch_no_qv("cancel_noqv", 40);
    check("cancel_div_hold", bus.div_res, 32'd14);

    // A cancel that arrives together with d_valid in IDLE must not start an operation.
    bus.cancel = 1'b1;
    issue(1'b1, 32'd9, 32'd3);
    bus.cancel = 1'b0;
    check("idle_cancel_ready", 32'(bus.ready), 32'd1);
    watch_no_qv("idle_cancel_noqv", 40);

    // A reset in cycle 20 must abort the operation and clear the outputs.
    issue(1'b1, 32'd50, 32'd5);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_qv", 32'(bus.q_valid), 32'd0);
    check("midrst_div", bus.div_res, 32'd0);
    check("midrst_mod", bus.mod_res, 32'd0);
    watch_no_qv("midrst_noqv", 40);

    // Back-to-back issue: each new request is presented during the previous q_valid cycle.
    ru = 1'b0;
    rl = 32'hFFFF_FF9C;
    rr = 32'd7;
    ref_div(ru, rl, rr, q_exp, m_exp);
    issue(ru, rl, rr);
    wait_qv(n);
    for (int i = 0; i < 6; i++) begin
      check("b2b_lat", 32'(n), 32'(Lat));
      check("b2b_div", bus.div_res, q_exp);
      check("b2b_mod", bus.mod_res, m_exp);
      check("b2b_ready", 32'(bus.ready), 32'd1);
      ru = 1'($urandom_range(0, 1));
      rl = $urandom;
      rr = (i % 2 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 3 == 2) rr = -rr;
      ref_div(ru, rl, rr, q_exp, m_exp);
      issue(ru, rl, rr);
      wait_qv(n);
    end
    check("b2b_last_lat", 32'(n), 32'(Lat));
    check("b2b_last_div", bus.div_res, q_exp);
    check("b2b_last_mod", bus.mod_res, m_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
